// File: rtl/dma_controller_if.sv
// Signal bundle of the DMA controller: CPU command, bus arbitration,
// device block port and memory write port.
interface dma_controller_if #(
  parameter int WORD_SIZE   = 16,
  parameter int BLOCK_WORDS = 4
);
  logic                              cmd_valid;
  logic [15:0]                       cmd_addr;
  logic [1:0]                        cmd_length;
  logic                              BR;
  logic                              BG;
  logic [1:0]                        offset;
  logic [BLOCK_WORDS*WORD_SIZE-1:0]  dev_data;
  logic                              mem_write;
  logic [15:0]                       mem_addr;
  logic [WORD_SIZE-1:0]              mem_data;
  logic                              mem_ready;
  logic                              busy;
  logic                              dma_end;

  // DMA controller side
  modport master (
    input  cmd_valid, cmd_addr, cmd_length, BG, dev_data, mem_ready,
    output BR, offset, mem_write, mem_addr, mem_data, busy, dma_end
  );

  // CPU / device / memory side
  modport slave (
    output cmd_valid, cmd_addr, cmd_length, BG, dev_data, mem_ready,
    input  BR, offset, mem_write, mem_addr, mem_data, busy, dma_end
  );
endinterface

// File: rtl/dma_controller.sv
// Cycle-stealing DMA controller: fetches device blocks one at a time and
// writes them word by word (most significant word first) into memory,
// releasing the bus between blocks.
module dma_controller #(
  parameter int WORD_SIZE   = 16,
  parameter int BLOCK_WORDS = 4,
  parameter int MAX_BLOCKS  = 3
) (
  input  logic             clk,
  input  logic             reset,
  dma_controller_if.master bus
);
  localparam int BLOCK_BITS = BLOCK_WORDS * WORD_SIZE;
  localparam int WORD_IDX_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(BLOCK_WORDS - 1);
  localparam logic [1:0] LEN_CAP = (MAX_BLOCKS > 3) ? 2'd3 : 2'(MAX_BLOCKS);

  typedef enum logic [2:0] {IDLE, REQ, XFER, REL, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [15:0]            base_reg, base_next;
  logic [1:0]             len_reg, len_next;
  logic [1:0]             blk_reg, blk_next;
  logic [WORD_IDX_W-1:0]  word_reg, word_next;
  logic [BLOCK_BITS-1:0]  buffer_reg, buffer_next;
  logic [1:0]             len_cmd;
  logic [15:0]            word_addr;
  logic [WORD_SIZE-1:0]   buffer_words [BLOCK_WORDS];

  // Word k of the buffered block sits at the k-th slice from the top.
  generate
    for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_word
      assign buffer_words[gi] = buffer_reg[WORD_SIZE*(BLOCK_WORDS-1-gi) +: WORD_SIZE];
    end
  endgenerate

  // Memory address of the current word, 16-bit wrap-around.
  assign word_addr = base_reg + 16'(blk_reg) * 16'(BLOCK_WORDS) + 16'(word_reg);

  // Requested block count, never more than the device holds.
  always_comb begin
    len_cmd = bus.cmd_length;
    if (bus.cmd_length > LEN_CAP) len_cmd = LEN_CAP;
  end

  // State and transfer context registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      base_reg   <= '0;
      len_reg    <= '0;
      blk_reg    <= '0;
      word_reg   <= '0;
      buffer_reg <= '0;
    end else begin
      state_reg  <= state_next;
      base_reg   <= base_next;
      len_reg    <= len_next;
      blk_reg    <= blk_next;
      word_reg   <= word_next;
      buffer_reg <= buffer_next;
    end
  end

  // Next-state logic and state-decoded outputs; mem_write follows BG so a
  // withdrawn grant pauses the transfer within the same cycle.
  always_comb begin
    state_next    = state_reg;
    base_next     = base_reg;
    len_next      = len_reg;
    blk_next      = blk_reg;
    word_next     = word_reg;
    buffer_next   = buffer_reg;
    bus.BR        = 1'b0;
    bus.offset    = 2'b11;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_data  = '0;
    bus.busy      = 1'b0;
    bus.dma_end   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          base_next  = bus.cmd_addr;
          len_next   = len_cmd;
          blk_next   = '0;
          word_next  = '0;
          state_next = (len_cmd == 2'd0) ? DONE : REQ;
        end
      end
      REQ: begin
        bus.busy   = 1'b1;
        bus.BR     = 1'b1;
        bus.offset = blk_reg;
        if (bus.BG) begin
          buffer_next = bus.dev_data;
          word_next   = '0;
          state_next  = XFER;
        end
      end
      XFER: begin
        bus.busy      = 1'b1;
        bus.BR        = 1'b1;
        bus.offset    = blk_reg;
        bus.mem_write = bus.BG;
        bus.mem_addr  = word_addr;
        bus.mem_data  = buffer_words[word_reg];
        if (bus.BG && bus.mem_ready) begin
          if (word_reg == LAST_WORD) begin
            word_next  = '0;
            blk_next   = blk_reg + 2'd1;
            state_next = REL;
          end else begin
            word_next = word_reg + 1'b1;
          end
        end
      end
      REL: begin
        bus.busy = 1'b1;
        if (!bus.BG) state_next = (blk_reg < len_reg) ? REQ : DONE;
      end
      DONE: begin
        bus.dma_end = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dma_controller.sv
// Scoreboard bench for dma_controller: expected memory writes are queued
// when a command is issued and popped as the memory port accepts words.
module tb_dma_controller;
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dma_controller_if #(.WORD_SIZE(16), .BLOCK_WORDS(4)) bus ();

  dma_controller #(.WORD_SIZE(16), .BLOCK_WORDS(4), .MAX_BLOCKS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wr_t         exp_q [$];
  logic [63:0] dev_blocks [3];
  int          checks_cnt  = 0;
  int          errors_cnt  = 0;
  int          end_count   = 0;
  int          br_falls    = 0;
  int          br_cycles   = 0;
  int          write_count = 0;
  logic        br_prev     = 1'b0;
  logic        br_s        = 1'b0;
  logic [15:0] last_addr   = 16'h0;
  bit          pause_en    = 1'b0;
  bit          pause_hit   = 1'b0;
  logic [15:0] pause_addr  = 16'h0;
  int          pause_at    = -100;
  int          cyc         = 0;
  bit          stall_en    = 1'b0;
  logic [15:0] stall_addr  = 16'h0;
  int          stall_seen  = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Device model: block selected by offset.
  assign bus.dev_data = (bus.offset == 2'd3) ? 64'h0 : dev_blocks[bus.offset];

  // CPU arbiter model: BG follows BR one cycle later, with an optional
  // three-cycle withdrawal window.
  initial begin
    bus.BG = 1'b0;
    forever begin
      @(negedge clk);
      br_s = bus.BR;
      @(posedge clk);
      #1;
      cyc++;
      if (pause_hit && cyc > pause_at && cyc <= pause_at + 3) bus.BG = 1'b0;
      else bus.BG = br_s;
    end
  end

  // Memory model and monitor, evaluated mid-cycle.
  initial begin
    bus.mem_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_en && stall_seen < 2 && bus.mem_write && bus.mem_addr == stall_addr) begin
        bus.mem_ready = 1'b0;
        stall_seen++;
      end else begin
        bus.mem_ready = 1'b1;
      end
      if (bus.mem_write) begin
        if (exp_q.size() == 0) begin
          check_value("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          check_value("wr_addr", 32'(bus.mem_addr), 32'(exp_q[0].addr));
          check_value("wr_data", 32'(bus.mem_data), 32'(exp_q[0].data));
          if (bus.mem_ready) begin
            $display("WR addr %h data %h", bus.mem_addr, bus.mem_data);
            void'(exp_q.pop_front());
            write_count++;
            last_addr = bus.mem_addr;
            if (pause_en && !pause_hit && bus.mem_addr == pause_addr) begin
              pause_hit = 1'b1;
              pause_at  = cyc;
            end
          end
        end
      end
      if (!bus.BG) check_value("wr_without_bg", 32'(bus.mem_write), 32'd0);
      if (!bus.BR) check_value("offset_parked", 32'(bus.offset), 32'd3);
      if (br_prev && !bus.BR) br_falls++;
      if (bus.BR) br_cycles++;
      br_prev = bus.BR;
      if (bus.dma_end) end_count++;
    end
  end

  task automatic check_reset_outputs();
    check_value("rst_br",        32'(bus.BR),        32'd0);
    check_value("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check_value("rst_busy",      32'(bus.busy),      32'd0);
    check_value("rst_dma_end",   32'(bus.dma_end),   32'd0);
    check_value("rst_offset",    32'(bus.offset),    32'd3);
    check_value("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check_value("rst_mem_data",  32'(bus.mem_data),  32'd0);
  endtask

  task automatic issue_cmd(input logic [15:0] addr, input logic [1:0] len);
    for (int b = 0; b < int'(len); b++) begin
      for (int k = 0; k < 4; k++) begin
        wr_t w;
        w.addr = addr + 16'(b * 4 + k);
        w.data = dev_blocks[b][16*(3-k) +: 16];
        exp_q.push_back(w);
      end
    end
    $display("CMD addr %h len %0d", addr, len);
    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_addr   = addr;
    bus.cmd_length = len;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [15:0] addr, input logic [1:0] len,
                         input bit poke_mid, input bit poke_end);
    int ends0, falls0, brc0, wr0, end_cyc;
    bit seen;
    ends0 = end_count; falls0 = br_falls; brc0 = br_cycles; wr0 = write_count;
    seen = 1'b0; end_cyc = -1;
    issue_cmd(addr, len);
    check_value("busy_after_accept", 32'(bus.busy), (len != 2'd0) ? 32'd1 : 32'd0);
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (poke_mid && c == 4) begin
        bus.cmd_valid  = 1'b1;
        bus.cmd_addr   = 16'h7700;
        bus.cmd_length = 2'd1;
      end else if (poke_mid && c == 5) begin
        bus.cmd_valid = 1'b0;
      end
      if (bus.dma_end) begin
        seen    = 1'b1;
        end_cyc = c;
        check_value("busy_at_end", 32'(bus.busy), 32'd0);
        if (poke_end) begin
          bus.cmd_valid  = 1'b1;
          bus.cmd_addr   = 16'h5500;
          bus.cmd_length = 2'd1;
        end
      end
    end
    bus.cmd_valid = poke_end ? bus.cmd_valid : 1'b0;
    check_value("dma_end_seen", 32'(seen), 32'd1);
    if (len == 2'd0) check_value("end_latency", 32'(end_cyc), 32'd0);
    if (poke_end) begin
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
    end
    @(negedge clk);
    check_value("end_one_cycle", 32'(bus.dma_end), 32'd0);
    check_value("end_count", 32'(end_count - ends0), 32'd1);
    check_value("sb_drained", 32'(exp_q.size()), 32'd0);
    check_value("write_count", 32'(write_count - wr0), 32'(int'(len) * 4));
    check_value("br_releases", 32'(br_falls - falls0), 32'(len));
    if (len == 2'd0) check_value("br_cycles", 32'(br_cycles - brc0), 32'd0);
    if (poke_end) begin
      repeat (3) @(negedge clk);
      check_value("end_cmd_ignored_busy", 32'(bus.busy), 32'd0);
      check_value("end_cmd_ignored_br",   32'(bus.BR),   32'd0);
    end
  endtask

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int ends0;
    int c;
    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_addr   = 16'h0;
    bus.cmd_length = 2'd0;
    dev_blocks[0]  = 64'h0;
    dev_blocks[1]  = 64'h0;
    dev_blocks[2]  = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;

    // Three blocks, continuous grant, a stray command mid-transfer.
    dev_blocks[0] = 64'hA000_A001_A002_A003;
    dev_blocks[1] = 64'hB010_B011_B012_B013;
    dev_blocks[2] = 64'hC020_C021_C022_C023;
    run_cmd(16'h01F4, 2'd3, 1'b1, 1'b0);

    // Zero-length command, with a command on the dma_end cycle.
    run_cmd(16'h0800, 2'd0, 1'b0, 1'b1);

    // Grant withdrawn for three cycles after word 1 of block 0.
    dev_blocks[0] = 64'h1111_2222_3333_4444;
    dev_blocks[1] = 64'h5555_6666_7777_8888;
    pause_en   = 1'b1;
    pause_addr = 16'h1001;
    run_cmd(16'h1000, 2'd2, 1'b0, 1'b0);
    check_value("pause_hit", 32'(pause_hit), 32'd1);
    pause_en = 1'b0;

    // Memory not ready for two cycles on word 0.
    dev_blocks[0] = 64'hDEAD_BEEF_CAFE_F00D;
    stall_en   = 1'b1;
    stall_addr = 16'h2340;
    run_cmd(16'h2340, 2'd1, 1'b0, 1'b0);
    check_value("stall_cycles", 32'(stall_seen), 32'd2);
    stall_en = 1'b0;

    // Address wrap.
    dev_blocks[0] = 64'h0F0F_1E1E_2D2D_3C3C;
    run_cmd(16'hFFFE, 2'd1, 1'b0, 1'b0);

    // Reset in the middle of block 1.
    dev_blocks[0] = 64'h3000_3001_3002_3003;
    dev_blocks[1] = 64'h3100_3101_3102_3103;
    dev_blocks[2] = 64'h3200_3201_3202_3203;
    issue_cmd(16'h3000, 2'd3);
    c = 0;
    while (last_addr != 16'h3005 && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    check_value("reset_trigger", 32'(last_addr), 32'h3005);
    ends0 = end_count;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    exp_q.delete();
    repeat (10) @(posedge clk);
    #1;
    check_value("no_end_after_reset", 32'(end_count - ends0), 32'd0);
    check_value("idle_after_reset", 32'(bus.busy), 32'd0);

    // A fresh command after the abandoned one.
    dev_blocks[0] = {$urandom, $urandom};
    dev_blocks[1] = {$urandom, $urandom};
    run_cmd(16'h4A00, 2'd2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
